sharpen_window_gen: RTL and testbench
=====================================

// Module: sharpen_window_gen
// PURPOSE
// - Raster-to-window stage directly upstream of the 3x3 sharpening convolution.
// - Accepts one 8-bit unsigned pixel per valid cycle, in row-major order.
// - Buffers the two previous rows and presents a full 3x3 neighbourhood of 9-bit signed samples.
// - The convolution stage consumes this window together with its 8-bit signed filter.
// PARAMETERS
// - IMG_W   640  pixels per row (>=3); sets the line-buffer depth
// - IMG_H   480  rows per frame (>=3)
// - PIX_W   8    input pixel width; window samples are PIX_W+1 bits signed
// PORTS
// - clk        in   1             single clock; all logic on posedge
// - rst        in   1             synchronous, active-high reset
// - in_valid   in   1             pixel qualifier; no backpressure, in_ready does not exist
// - in_sof     in   1             start of frame; sampled only with in_valid, marks pixel (0,0)
// - in_pix     in   PIX_W         unsigned pixel
// - win        out  [0:2][0:2]x9  signed window; [0][*]=row r-2, [2][*]=row r, [*][2]=col c
// - win_valid  out  1             win holds a complete neighbourhood this cycle
// - win_row    out  clog2(IMG_H)  centre row of win (r-1)
// - win_col    out  clog2(IMG_W)  centre column of win (c-1)
// - frame_done out  1             one-cycle pulse after the last pixel of a frame
// BEHAVIOUR
// - Reset: win=0, win_valid=0, win_row=0, win_col=0, frame_done=0, state=IDLE, counters=0.
//   Line-buffer contents are not cleared; they are never read before being rewritten.
// - Sample extension: sample = {1'b0, in_pix}. 255 becomes +255 and is never negative.
// - States:
//   - IDLE: ignore pixels until in_valid&in_sof. That pixel is (0,0); go to FILL.
//   - FILL: rows 0..1. Write pixels into the line buffers; win_valid stays 0.
//     Leaving column IMG_W-1 of row 1 goes to STREAM.
//   - STREAM: rows 2..IMG_H-1. The pixel at (IMG_H-1, IMG_W-1) goes to IDLE and pulses frame_done.
// - Counters col/row advance only on in_valid. col wraps IMG_W-1 -> 0 and increments row.
// - Idle cycles (in_valid=0) freeze all state. win_valid=0 on those cycles; win holds its value.
// - Shift register: a 3x3 register shifts left on each accepted pixel.
//   New column = {lb1[col], lb0[col], sample}.
//   Line buffers are read-before-write: lb1[col] <= lb0[col], lb0[col] <= sample.
// - Output rule: win_valid=1 exactly one cycle after an accepted pixel with row>=2 && col>=2.
//   Latency is 1 clk.
//   Yields (IMG_W-2)*(IMG_H-2) windows per frame; border pixels produce no window.
// - Row wrap: columns 0..1 of each new row only refill the shift register.
//   No window straddles two rows.
// - Mid-frame in_valid&in_sof from any state: treat as (0,0) of a new frame and discard the partial frame.
//   Go to FILL with no frame_done. win_valid for that pixel is 0.
// - in_sof while in FILL/STREAM at exactly (0,0) position after IDLE is the normal case.
// - in_sof without in_valid is ignored.
// - Reset mid-frame: next cycle outputs are at reset values. A new in_sof is required.
// - Same-cycle events: frame_done and a restarting in_sof cannot coincide.
//   The last pixel consumes that cycle; an in_sof on the next pixel starts a new frame normally.
// STRUCTURE
// - Shared package img_pkg:
//   - PIX_W and WIN_W=9 constants
//   - typedef logic signed [8:0] sample_t
//   - typedef sample_t win_t[0:2][0:2]
//   - typedef enum {IDLE, FILL, STREAM} wg_state_t
// - Sub-module line_buffer #(DEPTH, W): one read and one write port, same address.
//   Read-before-write, registered. Instantiate twice (lb0, lb1); infers BRAM at IMG_W=640.
// TESTING
// - IMG_W=4, IMG_H=4, pix=4r+c streamed with in_sof on (0,0):
//   - first win_valid one clk after pix 10; win=[[0,1,2],[4,5,6],[8,9,10]], row=1, col=1
//   - exactly 4 windows; the last is [[5,6,7],[9,10,11],[13,14,15]]
//   - frame_done one clk after pix 15
// - Same frame with in_valid toggled 1/0 every cycle: identical window sequence.
//   win_valid never high on idle cycles.
// - Pixel 255 at (2,2): win[2][2]=+255 (9'h0FF), not -1.
// - in_sof reasserted at pixel index 9 of a frame: no window emitted for the old frame.
//   No frame_done. The new frame yields its first window after its own 11th pixel.
// - rst asserted after pixel 11 for one cycle: all outputs 0 next cycle.
//   Pixels without in_sof are ignored; a new frame then runs clean.
// - Back-to-back frames (sof right after frame_done pixel): both produce 4 windows.
//   The second frame's windows contain no stale first-frame data.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline types: pixel/sample widths, the 3x3 window type and the
// window-generator state encoding.
package img_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_W = PIX_W + 1;

  typedef logic signed [WIN_W-1:0] sample_t;
  typedef sample_t win_t [0:2][0:2];
  typedef enum logic [1:0] {IDLE, FILL, STREAM} wg_state_t;
endpackage

// File: rtl/line_buffer.sv
// Single-row pixel store with one registered read port and one write port;
// a read and a write to the same address return the old contents.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wdata;
    rdata <= mem[rd_addr];
  end

endmodule

// File: rtl/sharpen_window_gen.sv
// Raster-to-3x3-window stage feeding the sharpening convolution.
// state  | meaning
// IDLE   | waiting for in_valid & in_sof
// FILL   | rows 0..1, line buffers filling, no windows
// STREAM | rows 2..IMG_H-1, one window per pixel with col >= 2
module sharpen_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = img_pkg::PIX_W,
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output img_pkg::win_t    win,
  output logic             win_valid,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             frame_done
);

  import img_pkg::sample_t;
  import img_pkg::wg_state_t;
  import img_pkg::IDLE;
  import img_pkg::FILL;
  import img_pkg::STREAM;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  wg_state_t        state;
  logic [COL_W-1:0] col, pos_col, nxt_col, rd_addr;
  logic [ROW_W-1:0] row, pos_row, nxt_row;
  logic             acc, last_col, last_pix;
  logic [PIX_W-1:0] lb0_q, lb1_q;

  // An sof pixel is always (0,0), whatever the counters say.
  always_comb begin
    acc      = in_valid && (in_sof || state != IDLE);
    pos_col  = in_sof ? '0 : col;
    pos_row  = in_sof ? '0 : row;
    last_col = (pos_col == COL_LAST);
    last_pix = last_col && (pos_row == ROW_LAST);
    nxt_col  = last_col ? '0 : pos_col + 1'b1;
    nxt_row  = last_pix ? '0 : (last_col ? pos_row + 1'b1 : pos_row);
    rd_addr  = rst ? '0 : (acc ? nxt_col : col);
  end

  // Reads are prefetched at the column of the next pixel so that the buffer
  // output is ready on the cycle that pixel is accepted.
  line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb0 (
    .clk    (clk),
    .we     (acc),
    .wr_addr(pos_col),
    .wdata  (in_pix),
    .rd_addr(rd_addr),
    .rdata  (lb0_q)
  );

  line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
    .clk    (clk),
    .we     (acc),
    .wr_addr(pos_col),
    .wdata  (lb0_q),
    .rd_addr(rd_addr),
    .rdata  (lb1_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (acc) begin
        col <= nxt_col;
        row <= nxt_row;
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= sample_t'({1'b0, lb1_q});
        win[1][2] <= sample_t'({1'b0, lb0_q});
        win[2][2] <= sample_t'({1'b0, in_pix});
        if (pos_row >= ROW_W'(2) && pos_col >= COL_W'(2)) begin
          win_valid <= 1'b1;
          win_row   <= pos_row - 1'b1;
          win_col   <= pos_col - 1'b1;
        end
        if (last_pix) begin
          state      <= IDLE;
          frame_done <= 1'b1;
        end else if (nxt_row >= ROW_W'(2)) begin
          state <= STREAM;
        end else begin
          state <= FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_sharpen_window_gen.sv
// Self-checking bench for sharpen_window_gen on a 4x4 image; a frame-level
// model records each pixel by raster index and derives the expected windows.
module tb_sharpen_window_gen;
  import img_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_pix;
  win_t       win;
  logic       win_valid;
  logic [1:0] win_row;
  logic [1:0] win_col;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sharpen_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pix    (in_pix),
    .win       (win),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .frame_done(frame_done)
  );

  // Reference model: current frame image, position, and per-cycle expectations.
  int img [0:H-1][0:W-1];
  bit m_active = 1'b0;
  int m_idx = 0;
  bit exp_valid, exp_done;
  int exp_r, exp_c;
  int n_win = 0;
  int n_done = 0;

  function automatic logic [80:0] win_flat(input win_t w);
    logic [80:0] f;
    f = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        f[(i*3+j)*9 +: 9] = w[i][j];
    return f;
  endfunction

  function automatic logic [80:0] model_flat();
    logic [80:0] f;
    f = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        f[(i*3+j)*9 +: 9] = 9'(img[exp_r-1+i][exp_c-1+j]);
    return f;
  endfunction

  function automatic logic [80:0] list_flat(input int v[9]);
    logic [80:0] f;
    f = '0;
    for (int k = 0; k < 9; k++) f[k*9 +: 9] = 9'(v[k]);
    return f;
  endfunction

  task automatic drive(input bit v, input bit s, input int p);
    in_valid  = v;
    in_sof    = s;
    in_pix    = 8'(p);
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (v && s) begin
      m_active = 1'b1;
      m_idx    = 0;
    end
    if (v && m_active) begin
      int r, c;
      r = m_idx / W;
      c = m_idx % W;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        exp_valid = 1'b1;
        exp_r     = r - 1;
        exp_c     = c - 1;
      end
      if (m_idx == W*H-1) begin
        exp_done = 1'b1;
        m_active = 1'b0;
      end
      m_idx++;
    end
    @(posedge clk);
    #1;
    if (win_valid === 1'b1) n_win++;
    if (frame_done === 1'b1) n_done++;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    m_active = 1'b0;
  endtask

  task automatic test_reset();
    in_pix = 8'hA5;
    do_reset();
    n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b want=0", win_valid); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0b want=0", frame_done); end
    n_cmp++; if (win_row !== 2'd0 || win_col !== 2'd0) begin n_err++; $display("FAIL reset_pos got=%0d,%0d want=0,0", win_row, win_col); end
    n_cmp++; if (win_flat(win) !== 81'd0) begin n_err++; $display("FAIL reset_win got=%h want=0", win_flat(win)); end
  endtask

  task automatic test_ramp();
    int w0, d0;
    int first[9];
    int last[9];
    first = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    last  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    w0 = n_win; d0 = n_done;
    for (int k = 0; k < W*H; k++) begin
      drive(1'b1, k == 0, k);
      n_cmp++; if (win_valid !== exp_valid) begin n_err++; $display("FAIL ramp_valid k=%0d got=%0b want=%0b", k, win_valid, exp_valid); end
      n_cmp++; if (frame_done !== exp_done) begin n_err++; $display("FAIL ramp_done k=%0d got=%0b want=%0b", k, frame_done, exp_done); end
      if (exp_valid) begin
        n_cmp++;
        if (win_flat(win) !== model_flat() || win_row !== 2'(exp_r) || win_col !== 2'(exp_c)) begin
          n_err++; $display("FAIL ramp_win k=%0d got=%h @%0d,%0d want=%h @%0d,%0d", k, win_flat(win), win_row, win_col, model_flat(), exp_r, exp_c);
        end
      end
      if (k == 10) begin
        n_cmp++;
        if (win_valid !== 1'b1 || win_flat(win) !== list_flat(first) || win_row !== 2'd1 || win_col !== 2'd1) begin
          n_err++; $display("FAIL ramp_first got=%h v=%0b @%0d,%0d want=%h v=1 @1,1", win_flat(win), win_valid, win_row, win_col, list_flat(first));
        end
      end
      if (k == 15) begin
        n_cmp++;
        if (win_flat(win) !== list_flat(last) || frame_done !== 1'b1) begin
          n_err++; $display("FAIL ramp_last got=%h done=%0b want=%h done=1", win_flat(win), frame_done, list_flat(last));
        end
      end
    end
    n_cmp++; if (n_win - w0 != 4) begin n_err++; $display("FAIL ramp_count got=%0d want=4", n_win - w0); end
    n_cmp++; if (n_done - d0 != 1) begin n_err++; $display("FAIL ramp_done_count got=%0d want=1", n_done - d0); end
  endtask

  task automatic test_gaps();
    int w0;
    logic [80:0] held;
    w0 = n_win;
    held = win_flat(win);
    for (int k = 0; k < 2*W*H; k++) begin
      if (k % 2 == 0) drive(1'b1, k == 0, k / 2);
      else            drive(1'b0, 1'b0, int'($urandom_range(0, 255)));
      n_cmp++; if (win_valid !== exp_valid) begin n_err++; $display("FAIL gaps_valid k=%0d got=%0b want=%0b", k, win_valid, exp_valid); end
      n_cmp++; if (frame_done !== exp_done) begin n_err++; $display("FAIL gaps_done k=%0d got=%0b want=%0b", k, frame_done, exp_done); end
      if (exp_valid) begin
        n_cmp++;
        if (win_flat(win) !== model_flat() || win_row !== 2'(exp_r) || win_col !== 2'(exp_c)) begin
          n_err++; $display("FAIL gaps_win k=%0d got=%h want=%h", k, win_flat(win), model_flat());
        end
      end
      if (k % 2 == 1) begin
        n_cmp++; if (win_flat(win) !== held) begin n_err++; $display("FAIL gaps_hold k=%0d got=%h want=%h", k, win_flat(win), held); end
      end
      held = win_flat(win);
    end
    n_cmp++; if (n_win - w0 != 4) begin n_err++; $display("FAIL gaps_count got=%0d want=4", n_win - w0); end
  endtask

  task automatic test_max_pixel();
    for (int k = 0; k < W*H; k++) begin
      drive(1'b1, k == 0, (k == 2*W+2) ? 255 : int'($urandom_range(0, 254)));
      if (k == 2*W+2) begin
        n_cmp++; if (win_valid !== 1'b1 || win[2][2] !== 9'h0FF) begin n_err++; $display("FAIL max_sample got=%h v=%0b want=0ff v=1", win[2][2], win_valid); end
        n_cmp++; if (win_flat(win) !== model_flat()) begin n_err++; $display("FAIL max_win got=%h want=%h", win_flat(win), model_flat()); end
      end
    end
  endtask

  task automatic test_sof_restart();
    int w0, d0, first_k;
    w0 = n_win; d0 = n_done; first_k = -1;
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, k == 0, int'($urandom_range(0, 255)));
      n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL restart_old_valid k=%0d got=%0b want=0", k, win_valid); end
    end
    for (int k = 0; k < W*H; k++) begin
      drive(1'b1, k == 0, int'($urandom_range(0, 255)));
      if (win_valid === 1'b1 && first_k < 0) first_k = k;
      n_cmp++; if (win_valid !== exp_valid) begin n_err++; $display("FAIL restart_valid k=%0d got=%0b want=%0b", k, win_valid, exp_valid); end
      n_cmp++; if (frame_done !== exp_done) begin n_err++; $display("FAIL restart_done k=%0d got=%0b want=%0b", k, frame_done, exp_done); end
      if (exp_valid) begin
        n_cmp++; if (win_flat(win) !== model_flat()) begin n_err++; $display("FAIL restart_win k=%0d got=%h want=%h", k, win_flat(win), model_flat()); end
      end
    end
    n_cmp++; if (first_k != 10) begin n_err++; $display("FAIL restart_first got=%0d want=10", first_k); end
    n_cmp++; if (n_win - w0 != 4 || n_done - d0 != 1) begin n_err++; $display("FAIL restart_counts got=%0d/%0d want=4/1", n_win - w0, n_done - d0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    for (int k = 0; k < 12; k++) drive(1'b1, k == 0, int'($urandom_range(0, 255)));
    do_reset();
    n_cmp++; if (win_valid !== 1'b0 || frame_done !== 1'b0) begin n_err++; $display("FAIL rstmid_flags got=%0b%0b want=00", win_valid, frame_done); end
    n_cmp++; if (win_row !== 2'd0 || win_col !== 2'd0) begin n_err++; $display("FAIL rstmid_pos got=%0d,%0d want=0,0", win_row, win_col); end
    n_cmp++; if (win_flat(win) !== 81'd0) begin n_err++; $display("FAIL rstmid_win got=%h want=0", win_flat(win)); end
    w0 = n_win;
    for (int k = 0; k < 2*W*H; k++) begin
      drive(1'b1, 1'b0, int'($urandom_range(0, 255)));
      n_cmp++; if (win_valid !== 1'b0 || frame_done !== 1'b0) begin n_err++; $display("FAIL rstmid_ignored k=%0d got=%0b%0b want=00", k, win_valid, frame_done); end
    end
    for (int k = 0; k < W*H; k++) begin
      drive(1'b1, k == 0, int'($urandom_range(0, 255)));
      n_cmp++; if (win_valid !== exp_valid || frame_done !== exp_done) begin n_err++; $display("FAIL rstmid_new k=%0d got=%0b%0b want=%0b%0b", k, win_valid, frame_done, exp_valid, exp_done); end
      if (exp_valid) begin
        n_cmp++; if (win_flat(win) !== model_flat()) begin n_err++; $display("FAIL rstmid_win k=%0d got=%h want=%h", k, win_flat(win), model_flat()); end
      end
    end
    n_cmp++; if (n_win - w0 != 4) begin n_err++; $display("FAIL rstmid_count got=%0d want=4", n_win - w0); end
  endtask

  task automatic test_back_to_back();
    int w0, d0;
    for (int f = 0; f < 2; f++) begin
      w0 = n_win; d0 = n_done;
      for (int k = 0; k < W*H; k++) begin
        drive(1'b1, k == 0, int'($urandom_range(0, 255)));
        n_cmp++; if (win_valid !== exp_valid || frame_done !== exp_done) begin n_err++; $display("FAIL b2b_flags f=%0d k=%0d got=%0b%0b want=%0b%0b", f, k, win_valid, frame_done, exp_valid, exp_done); end
        if (exp_valid) begin
          n_cmp++;
          if (win_flat(win) !== model_flat() || win_row !== 2'(exp_r) || win_col !== 2'(exp_c)) begin
            n_err++; $display("FAIL b2b_win f=%0d k=%0d got=%h want=%h", f, k, win_flat(win), model_flat());
          end
        end
      end
      n_cmp++; if (n_win - w0 != 4 || n_done - d0 != 1) begin n_err++; $display("FAIL b2b_counts f=%0d got=%0d/%0d want=4/1", f, n_win - w0, n_done - d0); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pix   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ramp();
    test_gaps();
    test_max_pixel();
    test_sof_restart();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
